// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the text-page character buffer.
//   CHAR_SPACE / CHAR_LF / CHAR_BS / CHAR_CURSOR : control and fill codes
//   char_buf_state_t                             : buffer FSM state
//   is_printable()                               : printable ASCII test
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam logic [6:0] CHAR_SPACE  = 7'h20;
  localparam logic [6:0] CHAR_LF     = 7'h0A;
  localparam logic [6:0] CHAR_BS     = 7'h08;
  localparam logic [6:0] CHAR_CURSOR = 7'h5F;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } char_buf_state_t;

  // True for codes that occupy a cell (0x20..0x7E).
  function automatic logic is_printable(input logic [6:0] code);
    return (code >= 7'h20) && (code <= 7'h7E);
  endfunction

endpackage

// File: rtl/char_buf_ram.sv
// -----------------------------------------------------------------------------
// char_buf_ram
// Simple dual-port character RAM, DEPTH x 7 bits. One synchronous write port
// and one synchronous read port. A read and a write to the same address in
// the same cycle return the old contents. Contents have no reset; the owner
// is expected to initialise them.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, valid one clock after raddr
// -----------------------------------------------------------------------------
module char_buf_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [6:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [6:0]    rdata
);

  logic [6:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; non-blocking update gives read-before-write.
  always_ff @(posedge clk) begin
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/char_buf_text.sv
// -----------------------------------------------------------------------------
// char_buf_text
// Writable ROWS x COLS text page. A producer streams ASCII over a valid/ready
// port; printable codes are stored at the cursor, LF moves to the start of the
// next row, BS erases the previous cell. Rows and the page wrap (no scroll).
// After reset, and on clr_req, the page is blanked one cell per cycle.
// The read side returns the character at char_xy one clock later.
// Optional build macro CHAR_BUF_CURSOR_EN: a blinking '_' replaces the cell
// under the cursor while idle.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   wr_valid  : producer has a character
//   wr_char   : ASCII code from producer
//   wr_ready  : buffer accepts a character this cycle
//   clr_req   : single-cycle request to blank the page
//   busy      : clear in progress
//   char_xy   : read address {row, col}
//   char_code : character at char_xy, one cycle latency
//   cur_col   : cursor column
//   cur_row   : cursor row
// -----------------------------------------------------------------------------
module char_buf_text
  import vga_pkg::*;
#(
  parameter int          COLS      = 16,
  parameter int          ROWS      = 16,
  parameter int          COL_W     = $clog2(COLS),
  parameter int          ROW_W     = $clog2(ROWS),
  parameter logic [31:0] BLINK_DIV = 32'd20_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  input  logic [6:0]             wr_char,
  output logic                   wr_ready,
  input  logic                   clr_req,
  output logic                   busy,
  input  logic [ROW_W+COL_W-1:0] char_xy,
  output logic [6:0]             char_code,
  output logic [COL_W-1:0]       cur_col,
  output logic [ROW_W-1:0]       cur_row
);

  localparam int                CELLS     = ROWS * COLS;
  localparam int                ADDR_W    = $clog2(CELLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  char_buf_state_t   state_r;
  logic [ADDR_W-1:0] clr_addr_r;
  logic [COL_W-1:0]  cur_col_r;
  logic [ROW_W-1:0]  cur_row_r;
  logic              busy_r;
  logic              wr_ready_r;
  logic              space_r;

  logic              xfer_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [6:0]        ram_wdata_s;
  logic [ADDR_W-1:0] ram_raddr_s;
  logic [6:0]        ram_q_s;
  logic [COL_W-1:0]  nxt_col_s;
  logic [ROW_W-1:0]  nxt_row_s;
  logic [ROW_W-1:0]  rd_row_s;
  logic [COL_W-1:0]  rd_col_s;
  logic              rd_oob_s;
  logic              cursor_hit_s;

  // Row-major linear cell address; COLS need not be a power of two.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  // Next row with page wrap.
  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] row);
    return (row == LAST_ROW) ? {ROW_W{1'b0}} : row + ROW_W'(1);
  endfunction

  // Write-side decode: clear sweep or one accepted producer character.
  always_comb begin
    xfer_s      = wr_valid && wr_ready_r;
    nxt_col_s   = cur_col_r;
    nxt_row_s   = cur_row_r;
    ram_we_s    = 1'b0;
    ram_waddr_s = lin_addr(cur_row_r, cur_col_r);
    ram_wdata_s = CHAR_SPACE;
    if (state_r == CLEAR) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clr_addr_r;
    end else if (xfer_s) begin
      if (is_printable(wr_char)) begin
        ram_we_s    = 1'b1;
        ram_wdata_s = wr_char;
        if (cur_col_r == LAST_COL) begin
          nxt_col_s = {COL_W{1'b0}};
          nxt_row_s = row_inc(cur_row_r);
        end else begin
          nxt_col_s = cur_col_r + COL_W'(1);
        end
      end else if (wr_char == CHAR_LF) begin
        nxt_col_s = {COL_W{1'b0}};
        nxt_row_s = row_inc(cur_row_r);
      end else if (wr_char == CHAR_BS) begin
        if (cur_col_r != {COL_W{1'b0}}) begin
          nxt_col_s   = cur_col_r - COL_W'(1);
          ram_we_s    = 1'b1;
          ram_waddr_s = lin_addr(cur_row_r, cur_col_r - COL_W'(1));
        end else begin
          nxt_col_s = cur_col_r;
        end
      end else begin
        // Unsupported control code: consumed without effect.
        nxt_col_s = cur_col_r;
      end
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Read-side decode; out-of-page addresses read as blank.
  always_comb begin
    rd_row_s = char_xy[ROW_W+COL_W-1:COL_W];
    rd_col_s = char_xy[COL_W-1:0];
    rd_oob_s = (32'(rd_row_s) >= ROWS) || (32'(rd_col_s) >= COLS);
    if (rd_oob_s) begin
      ram_raddr_s = {ADDR_W{1'b0}};
    end else begin
      ram_raddr_s = lin_addr(rd_row_s, rd_col_s);
    end
  end

  // Control FSM: clear sweep, cursor and handshake registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= CLEAR;
      clr_addr_r <= {ADDR_W{1'b0}};
      cur_col_r  <= {COL_W{1'b0}};
      cur_row_r  <= {ROW_W{1'b0}};
      busy_r     <= 1'b1;
      wr_ready_r <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          if (clr_addr_r == LAST_ADDR) begin
            state_r    <= IDLE;
            clr_addr_r <= {ADDR_W{1'b0}};
            cur_col_r  <= {COL_W{1'b0}};
            cur_row_r  <= {ROW_W{1'b0}};
            busy_r     <= 1'b0;
            wr_ready_r <= 1'b1;
          end else begin
            clr_addr_r <= clr_addr_r + ADDR_W'(1);
          end
        end
        IDLE: begin
          // A character accepted alongside clr_req still lands first.
          cur_col_r <= nxt_col_s;
          cur_row_r <= nxt_row_s;
          if (clr_req) begin
            state_r    <= CLEAR;
            clr_addr_r <= {ADDR_W{1'b0}};
            busy_r     <= 1'b1;
            wr_ready_r <= 1'b0;
          end else begin
            busy_r     <= 1'b0;
            wr_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= CLEAR;
          clr_addr_r <= {ADDR_W{1'b0}};
          busy_r     <= 1'b1;
          wr_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Blank-forcing flag aligned with the RAM read register; also masks
  // the uninitialised read data during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      space_r <= 1'b1;
    end else begin
      space_r <= rd_oob_s;
    end
  end

`ifdef CHAR_BUF_CURSOR_EN
  logic [31:0]            blink_cnt_r;
  logic                   blink_on_r;
  logic [ROW_W+COL_W-1:0] rd_xy_r;

  // Free-running blink timer and read-address register for cursor overlay.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_r <= 32'd0;
      blink_on_r  <= 1'b0;
      rd_xy_r     <= {(ROW_W+COL_W){1'b0}};
    end else begin
      rd_xy_r <= char_xy;
      if (blink_cnt_r == BLINK_DIV - 32'd1) begin
        blink_cnt_r <= 32'd0;
        blink_on_r  <= ~blink_on_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 32'd1;
      end
    end
  end

  assign cursor_hit_s = blink_on_r && (state_r == IDLE) &&
                        (rd_xy_r == {cur_row_r, cur_col_r});
`else
  assign cursor_hit_s = 1'b0;
`endif

  char_buf_ram #(
    .DEPTH (CELLS),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .raddr (ram_raddr_s),
    .rdata (ram_q_s)
  );

  assign char_code = space_r      ? CHAR_SPACE  :
                     cursor_hit_s ? CHAR_CURSOR : ram_q_s;
  assign busy      = busy_r;
  assign wr_ready  = wr_ready_r;
  assign cur_col   = cur_col_r;
  assign cur_row   = cur_row_r;

endmodule

// File: tb/tb_char_buf_text.sv
// -----------------------------------------------------------------------------
// tb_char_buf_text
// Directed bench for char_buf_text (16 x 16 page). Stimulus pushes expected
// read data and state checks into queues; a monitor on the falling edge pops
// and compares them.
// -----------------------------------------------------------------------------
module tb_char_buf_text;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_char  = 7'h00;
  logic       clr_req  = 1'b0;
  logic [7:0] char_xy  = 8'h00;
  logic       wr_ready;
  logic       busy;
  logic [6:0] char_code;
  logic [3:0] cur_col;
  logic [3:0] cur_row;

  always #5 clk = ~clk;

  char_buf_text #(
    .COLS (16),
    .ROWS (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_char   (wr_char),
    .wr_ready  (wr_ready),
    .clr_req   (clr_req),
    .busy      (busy),
    .char_xy   (char_xy),
    .char_code (char_code),
    .cur_col   (cur_col),
    .cur_row   (cur_row)
  );

  typedef struct {
    string       name;
    logic [15:0] act;
    logic [15:0] exp;
  } chk_t;

  typedef struct {
    string      name;
    logic [6:0] exp;
  } rd_t;

  chk_t chk_q[$];
  rd_t  rd_q[$];
  logic rd_req   = 1'b0;
  logic rd_req_d = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Read data appears one clock after the address is presented.
  always @(posedge clk) rd_req_d <= rd_req;

  // Monitor: compare read data and posted state checks.
  always @(negedge clk) begin
    chk_t c;
    rd_t  r;
    if (rd_req_d) begin
      n_checks++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_underflow: got char_code %h with no expectation", char_code);
      end else begin
        r = rd_q.pop_front();
        if (char_code !== r.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", r.name, char_code, r.exp);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_checks++;
      if (c.act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", c.name, c.act, c.exp);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic check_cursor(input string name, input logic [3:0] col, input logic [3:0] row);
    check({name, "_col"}, 16'(cur_col), 16'(col));
    check({name, "_row"}, 16'(cur_row), 16'(row));
  endtask

  // Present one read address for a cycle and queue its expected data.
  task automatic rd(input logic [7:0] a, input logic [6:0] e, input string name);
    rd_t r;
    char_xy = a;
    r.name  = $sformatf("%s@%h", name, a);
    r.exp   = e;
    rd_q.push_back(r);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  // Offer one character; the transfer happens on the next rising edge.
  task automatic put(input logic [6:0] ch);
    int g;
    g = 0;
    while (wr_ready !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("put_ready", 16'(wr_ready), 16'd1);
    wr_valid = 1'b1;
    wr_char  = ch;
    @(negedge clk);
  endtask

  task automatic put_n(input logic [6:0] ch, input int n);
    for (int i = 0; i < n; i++) put(ch);
    wr_valid = 1'b0;
  endtask

  // Count falling edges with busy high, starting from 'start'.
  task automatic count_busy(input int start, output int cnt);
    cnt = start;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic read_all_blank(input string name);
    for (int a = 0; a < 256; a++) rd(8'(a), 7'h20, name);
  endtask

  initial begin
    int    cnt;
    string s;
    byte   b;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_char_code", 16'(char_code), 16'h0020);
    check("rst_busy", 16'(busy), 16'd1);
    check("rst_wr_ready", 16'(wr_ready), 16'd0);

    // Power-on clear: 256 busy cycles.
    rst_n = 1'b1;
    count_busy(0, cnt);
    check("por_busy_cycles", 16'(cnt), 16'd256);
    check("por_wr_ready", 16'(wr_ready), 16'd1);
    check_cursor("por_cursor", 4'd0, 4'd0);
    read_all_blank("por_blank");

    // Back-to-back string.
    s = "PLATFORMICO!";
    for (int i = 0; i < 12; i++) begin
      b = s[i];
      put(b[6:0]);
    end
    wr_valid = 1'b0;
    check_cursor("str_cursor", 4'd12, 4'd0);
    for (int i = 0; i < 12; i++) begin
      b = s[i];
      rd(8'(i), b[6:0], "str_cell");
    end
    rd(8'h0C, 7'h20, "str_after");

    // 16 line feeds wrap the page back to (0,0).
    put_n(7'h0A, 16);
    check_cursor("lf_wrap_cursor", 4'd0, 4'd0);

    // 20 'A' wrap onto row 1.
    put_n(7'h41, 20);
    check_cursor("a20_cursor", 4'd4, 4'd1);
    rd(8'h00, 7'h41, "a20_cell");
    rd(8'h0B, 7'h41, "a20_cell");
    rd(8'h0F, 7'h41, "a20_cell");
    rd(8'h10, 7'h41, "a20_cell");
    rd(8'h13, 7'h41, "a20_cell");
    rd(8'h14, 7'h20, "a20_after");

    // Move to (15,15), then 'Z' wraps the whole page.
    put_n(7'h0A, 14);
    check_cursor("lf14_cursor", 4'd0, 4'd15);
    put_n(7'h62, 15);
    check_cursor("b15_cursor", 4'd15, 4'd15);
    put_n(7'h5A, 1);
    check_cursor("z_wrap_cursor", 4'd0, 4'd0);
    rd(8'hFF, 7'h5A, "z_cell");
    rd(8'hFE, 7'h62, "b_cell");
    rd(8'hF0, 7'h62, "b_cell");

    // Backspace, line feed, unsupported code.
    put_n(7'h0A, 2);
    put(7'h63);
    put(7'h64);
    put(7'h65);
    wr_valid = 1'b0;
    check_cursor("cde_cursor", 4'd3, 4'd2);
    put_n(7'h08, 1);
    check_cursor("bs_cursor", 4'd2, 4'd2);
    rd(8'h22, 7'h20, "bs_cell");
    rd(8'h21, 7'h64, "bs_keep");
    put_n(7'h0A, 1);
    check_cursor("lf_cursor", 4'd0, 4'd3);
    put_n(7'h07, 1);
    check_cursor("bel_cursor", 4'd0, 4'd3);
    put_n(7'h08, 1);
    check_cursor("bs_col0_cursor", 4'd0, 4'd3);

    // Read and write of the same cell in one cycle returns old data.
    wr_valid = 1'b1;
    wr_char  = 7'h51;
    rd(8'h30, 7'h20, "rbw_old");
    wr_valid = 1'b0;
    rd(8'h30, 7'h51, "rbw_new");
    check_cursor("rbw_cursor", 4'd1, 4'd3);

    // Clear request together with a write: the write lands first.
    wr_valid = 1'b1;
    wr_char  = 7'h52;
    clr_req  = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    check("clr_wr_ready_low", 16'(wr_ready), 16'd0);
    cnt = (busy === 1'b1) ? 1 : 0;
    rd(8'h31, 7'h52, "clr_written");
    count_busy(cnt, cnt);
    check("clr_busy_cycles", 16'(cnt), 16'd256);
    check("clr_wr_ready", 16'(wr_ready), 16'd1);
    check_cursor("clr_cursor", 4'd0, 4'd0);
    read_all_blank("clr_blank");

    // Reset at clear cycle 100 restarts the full sweep.
    put_n(7'h58, 1);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 16'(busy), 16'd1);
    rst_n = 1'b1;
    count_busy(0, cnt);
    check("midrst_busy_cycles", 16'(cnt), 16'd256);
    check_cursor("midrst_cursor", 4'd0, 4'd0);
    rd(8'h00, 7'h20, "midrst_blank");
    rd(8'h31, 7'h20, "midrst_blank");
    rd(8'hFF, 7'h20, "midrst_blank");

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 16'(rd_q.size()), 16'd0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
